// File: rtl/apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : apb_req_arbiter
// Brief    : Round-robin arbiter sharing one APB master command port between
//            two requesters, with a watchdog that turns a hung slave into an
//            error response.
// Revision : 1.0 - initial release
// ============================================================================
module apb_req_arbiter #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  // requester 0
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp0_err,
  // requester 1
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic              rsp1_err,
  // APB master command interface
  output logic              m_transfer,
  output logic              m_read_write,
  output logic [ADDR_W-1:0] m_write_paddr,
  output logic [ADDR_W-1:0] m_read_paddr,
  output logic [DATA_W-1:0] m_write_data,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_slverr
);

  // Timer is at least one bit wide so a disabled watchdog still elaborates.
  localparam int TW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [TW-1:0] TIMER_LAST = (TIMEOUT_CYC > 0) ? TW'(TIMEOUT_CYC - 1) : '0;
  localparam logic [TW-1:0] TIMER_MAX  = '1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              grant_q, grant_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic sel_id;
  logic handshake;
  logic timeout_hit;

  // Requester selection: a lone requester wins, a tie goes to rr_ptr.
  // Ready is masked by reset so nothing is accepted while reset is asserted.
  always_comb begin
    sel_id      = (req0_valid & req1_valid) ? rr_ptr_q : req1_valid;
    handshake   = (state_q == S_IDLE) & (req0_valid | req1_valid) & PRESETn;
    req0_ready  = handshake & ~sel_id;
    req1_ready  = handshake & sel_id;
    timeout_hit = (TIMEOUT_CYC != 0) && (timer_q == TIMER_LAST);
  end

  // Next-state and datapath logic for the transaction sequencer.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    timer_d  = timer_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          grant_d  = sel_id;
          rr_ptr_d = ~sel_id;
          write_d  = sel_id ? req1_write : req0_write;
          addr_d   = sel_id ? req1_addr : req0_addr;
          // Reads present zero on the write-data bus.
          if (sel_id) wdata_d = req1_write ? req1_wdata : '0;
          else        wdata_d = req0_write ? req0_wdata : '0;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Saturating count; the timeout always fires before saturation.
        if (timer_q != TIMER_MAX) timer_d = timer_q + 1'b1;
        if (m_done) begin
          err_d   = m_slverr;
          rdata_d = (write_q | m_slverr) ? '0 : m_rdata;
          state_d = S_RESP;
        end else if (timeout_hit) begin
          err_d   = 1'b1;
          rdata_d = '0;
          state_d = S_RESP;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with asynchronous clear.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= S_IDLE;
      rr_ptr_q <= 1'b0;
      grant_q  <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      timer_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      timer_q  <= timer_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Output decode: command held from the latched request, response only to the winner.
  always_comb begin
    m_transfer    = (state_q == S_ISSUE);
    m_read_write  = write_q;
    m_write_paddr = addr_q;
    m_read_paddr  = addr_q;
    m_write_data  = wdata_q;
    rsp0_valid    = (state_q == S_RESP) & ~grant_q;
    rsp1_valid    = (state_q == S_RESP) & grant_q;
    rsp0_rdata    = rsp0_valid ? rdata_q : '0;
    rsp1_rdata    = rsp1_valid ? rdata_q : '0;
    rsp0_err      = rsp0_valid & err_q;
    rsp1_err      = rsp1_valid & err_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb_req_arbiter
// Brief    : Self-checking bench for apb_req_arbiter, directed scenarios plus
//            randomized traffic against a transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb_req_arbiter;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int TO     = 16;

  logic              PCLK;
  logic              PRESETn;
  logic              req0_valid, req0_ready, req0_write;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              rsp0_valid, rsp0_err;
  logic [DATA_W-1:0] rsp0_rdata;
  logic              req1_valid, req1_ready, req1_write;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              rsp1_valid, rsp1_err;
  logic [DATA_W-1:0] rsp1_rdata;
  logic              m_transfer, m_read_write;
  logic [ADDR_W-1:0] m_write_paddr, m_read_paddr;
  logic [DATA_W-1:0] m_write_data;
  logic              m_done, m_slverr;
  logic [DATA_W-1:0] m_rdata;

  apb_req_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_write(req0_write),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_write(req1_write),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .m_transfer(m_transfer), .m_read_write(m_read_write),
    .m_write_paddr(m_write_paddr), .m_read_paddr(m_read_paddr),
    .m_write_data(m_write_data), .m_done(m_done), .m_rdata(m_rdata),
    .m_slverr(m_slverr)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;

  // Reference model state: pending request per requester, and whose turn a tie is.
  logic       p_v [2];
  logic       p_w [2];
  logic [7:0] p_a [2];
  logic [7:0] p_d [2];
  int         turn;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #2;
  endtask

  task automatic drive_reqs();
    req0_valid = p_v[0]; req0_write = p_w[0]; req0_addr = p_a[0]; req0_wdata = p_d[0];
    req1_valid = p_v[1]; req1_write = p_w[1]; req1_addr = p_a[1]; req1_wdata = p_d[1];
  endtask

  task automatic set_req(input int k, input logic w, input logic [7:0] a, input logic [7:0] d);
    p_v[k] = 1'b1; p_w[k] = w; p_a[k] = a; p_d[k] = d;
  endtask

  // One full transaction; d = WAIT index at which m_done fires (>= TO means never).
  task automatic run_txn(input int d, input logic [7:0] rd, input logic se);
    int         win;
    logic       ew;
    logic [7:0] ea, ed, erd;
    logic       eerr, tmo;
    drive_reqs();
    #1;
    win = (p_v[0] && p_v[1]) ? turn : (p_v[1] ? 1 : 0);
    check("ready0", req0_ready, (win == 0));
    check("ready1", req1_ready, (win == 1));
    ew = p_w[win]; ea = p_a[win]; ed = ew ? p_d[win] : 8'h00;
    p_v[win] = 1'b0;
    turn = 1 - win;
    // ISSUE cycle; a stray m_done here must be ignored
    tick();
    drive_reqs();
    m_done  = ($urandom_range(0, 3) == 0);
    m_rdata = 8'($urandom);
    #1;
    check("m_transfer_issue", m_transfer, 1);
    check("m_read_write", m_read_write, ew);
    check("m_write_paddr", m_write_paddr, ea);
    check("m_read_paddr", m_read_paddr, ea);
    check("m_write_data", m_write_data, ed);
    check("ready_busy", {req1_ready, req0_ready}, 0);
    tick();
    m_done = 1'b0;
    #1;
    check("m_transfer_wait", m_transfer, 0);
    tmo = (d >= TO);
    for (int i = 0; i < TO; i++) begin
      if (i == d) begin
        m_done = 1'b1; m_rdata = rd; m_slverr = se;
        tick();
        m_done = 1'b0; m_slverr = 1'b0;
        break;
      end
      check("no_early_rsp", {rsp1_valid, rsp0_valid}, 0);
      tick();
    end
    eerr = tmo | se;
    erd  = (ew | eerr) ? 8'h00 : rd;
    #1;
    check("rsp0_valid", rsp0_valid, (win == 0));
    check("rsp1_valid", rsp1_valid, (win == 1));
    check("rsp_rdata", (win == 0) ? rsp0_rdata : rsp1_rdata, erd);
    check("rsp_err", (win == 0) ? rsp0_err : rsp1_err, eerr);
    check("cmd_hold_resp", m_write_paddr, ea);
    // Late completion for an aborted transfer must not create another response
    if (tmo) m_done = 1'b1;
    tick();
    m_done = 1'b0;
    #1;
    check("rsp_after", {rsp1_valid, rsp0_valid}, 0);
  endtask

  task automatic gen_random();
    for (int k = 0; k < 2; k++)
      if (!p_v[k] && $urandom_range(0, 1) == 1)
        set_req(k, 1'($urandom), 8'($urandom), 8'($urandom));
    if (!p_v[0] && !p_v[1])
      set_req(int'($urandom_range(0, 1)), 1'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic do_reset();
    PRESETn = 1'b0;
    p_v[0] = 1'b0; p_v[1] = 1'b0;
    drive_reqs();
    m_done = 1'b0; m_slverr = 1'b0; m_rdata = '0;
    turn = 0;
    repeat (2) @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                          rsp0_err, rsp1_err, m_transfer, m_read_write}, 0);
    check({tag, "_data"}, {rsp0_rdata, rsp1_rdata, m_write_paddr, m_read_paddr, m_write_data}, 0);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin p_v[k] = 0; p_w[k] = 0; p_a[k] = 0; p_d[k] = 0; end
    do_reset();
    #1;
    check_all_zero("reset");

    // Read from requester 0, completion on the third WAIT cycle
    set_req(0, 1'b0, 8'h12, 8'h00);
    run_txn(2, 8'hA5, 1'b0);
    // Write from requester 1
    set_req(1, 1'b1, 8'h30, 8'h5C);
    run_txn(1, 8'hEE, 1'b0);

    // Both held valid from reset: grants must alternate
    do_reset();
    for (int n = 0; n < 8; n++) begin
      if (!p_v[0]) set_req(0, 1'($urandom), 8'($urandom), 8'($urandom));
      if (!p_v[1]) set_req(1, 1'($urandom), 8'($urandom), 8'($urandom));
      run_txn(int'($urandom_range(0, 3)), 8'($urandom), 1'b0);
    end
    p_v[0] = 1'b0; p_v[1] = 1'b0;

    // Hung slave: watchdog abort, late m_done ignored
    set_req(1, 1'b0, 8'h77, 8'h00);
    run_txn(99, 8'h3C, 1'b0);
    // Slave error on a read
    set_req(0, 1'b0, 8'h55, 8'h00);
    run_txn(0, 8'hC3, 1'b1);

    // Reset in the middle of WAIT after a grant to requester 0
    do_reset();
    set_req(0, 1'b1, 8'h44, 8'h99);
    drive_reqs();
    tick();
    p_v[0] = 1'b0;
    drive_reqs();
    tick();
    tick();
    PRESETn = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) @(posedge PCLK);
    #2;
    PRESETn = 1'b1;
    turn = 0;
    for (int n = 0; n < 3; n++) begin
      #1;
      check("no_stray_rsp", {rsp1_valid, rsp0_valid, m_transfer}, 0);
      tick();
    end
    set_req(0, 1'b0, 8'h01, 8'h00);
    set_req(1, 1'b0, 8'h02, 8'h00);
    run_txn(1, 8'h11, 1'b0);
    p_v[1] = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int dly;
      gen_random();
      dly = ($urandom_range(0, 9) == 0) ? 99 : int'($urandom_range(0, 6));
      run_txn(dly, 8'($urandom), ($urandom_range(0, 4) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks %0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire
